// File: rtl/display_register_shadow_pkg.sv
// Shared definitions for the display register shadow block and the
// display_controller it feeds.
//   - sprite register index constants (SPRITE0_X .. SPRITE1_ENABLE)
//   - commit FSM state type
//   - slot_width helper: index width needed to address N shadow slots
package display_register_shadow_pkg;

  localparam logic [6:0] SPRITE0_X      = 7'd2;
  localparam logic [6:0] SPRITE0_Y      = 7'd3;
  localparam logic [6:0] SPRITE0_TILE   = 7'd4;
  localparam logic [6:0] SPRITE0_ENABLE = 7'd5;
  localparam logic [6:0] SPRITE1_X      = 7'd6;
  localparam logic [6:0] SPRITE1_Y      = 7'd7;
  localparam logic [6:0] SPRITE1_TILE   = 7'd8;
  localparam logic [6:0] SPRITE1_ENABLE = 7'd9;

  // Encodings kept identical to the legacy localparam values.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } commit_state_t;

  function automatic int slot_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/display_register_shadow_regfile.sv
// shadow_regfile: NUM_SHADOW x DATA_WIDTH shadow storage with one dirty bit
// per slot.
//   clk, reset          clock, synchronous active-high reset (clears all)
//   wr_en/wr_slot/wr_data   CPU write port: stores data and sets dirty
//   clr_en/clr_slot     clears the dirty bit of a committed slot
//   rd_slot             combinational read address
//   rd_data/rd_dirty    value and dirty flag at rd_slot (pre-write contents)
module shadow_regfile
  import display_register_shadow_pkg::*;
#(
  parameter int NUM_SHADOW = 8,
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_W     = slot_width(NUM_SHADOW)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [SLOT_W-1:0]     wr_slot,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  clr_en,
  input  logic [SLOT_W-1:0]     clr_slot,
  input  logic [SLOT_W-1:0]     rd_slot,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_dirty
);

  logic [DATA_WIDTH-1:0] mem [NUM_SHADOW];
  logic [NUM_SHADOW-1:0] dirty;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_SHADOW; i++) begin
        mem[i] <= '0;
      end
      dirty <= '0;
    end else begin
      if (clr_en) begin
        dirty[clr_slot] <= 1'b0;
      end
      // Write is applied after the clear so a same-slot collision keeps
      // the new value pending for the next vblank.
      if (wr_en) begin
        mem[wr_slot]   <= wr_data;
        dirty[wr_slot] <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_data  = mem[rd_slot];
    rd_dirty = dirty[rd_slot];
  end

endmodule

// File: rtl/display_register_shadow.sv
// display_register_shadow: double-buffers CPU writes to the sprite registers
// of display_controller so they land atomically at the start of vblank.
// Non-shadowed indices pass straight through with one cycle of latency.
//   clk, reset               clock, synchronous active-high reset
//   cpu_write_i/index/value  CPU register write
//   in_vblank_i              display_controller in_vblank
//   register_write_o/index_o/write_value_o   registered write to the controller
//   commit_busy_o            high while the commit scan runs
//   frame_count_o            count of vblank rising edges (wraps at 16 bits)
module display_register_shadow
  import display_register_shadow_pkg::*;
#(
  parameter int BASE_INDEX  = int'(SPRITE0_X),
  parameter int NUM_SHADOW  = 8,
  parameter int INDEX_WIDTH = 7,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_write_i,
  input  logic [INDEX_WIDTH-1:0] cpu_index_i,
  input  logic [DATA_WIDTH-1:0]  cpu_value_i,
  input  logic                   in_vblank_i,
  output logic                   register_write_o,
  output logic [INDEX_WIDTH-1:0] register_index_o,
  output logic [DATA_WIDTH-1:0]  register_write_value_o,
  output logic                   commit_busy_o,
  output logic [15:0]            frame_count_o
);

  localparam int SLOT_W = slot_width(NUM_SHADOW);

  commit_state_t         state;
  logic [SLOT_W-1:0]     slot;
  logic                  vblank_prev;

  logic                  rise;
  logic                  in_range;
  logic [SLOT_W-1:0]     cpu_slot;
  logic                  shadow_wr;
  logic                  pass_wr;
  logic                  commit_go;
  logic                  commit_emit;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_dirty;

  always_comb begin
    rise      = in_vblank_i & ~vblank_prev;
    in_range  = (cpu_index_i >= INDEX_WIDTH'(BASE_INDEX)) &&
                (cpu_index_i <  INDEX_WIDTH'(BASE_INDEX + NUM_SHADOW));
    cpu_slot  = SLOT_W'(cpu_index_i - INDEX_WIDTH'(BASE_INDEX));
    shadow_wr = cpu_write_i & in_range;
    pass_wr   = cpu_write_i & ~in_range;
    // A pass-through write owns the output register; the scan holds its slot.
    commit_go   = (state == COMMIT) & ~pass_wr;
    commit_emit = commit_go & rd_dirty;
    commit_busy_o = (state == COMMIT);
  end

  shadow_regfile #(
    .NUM_SHADOW (NUM_SHADOW),
    .DATA_WIDTH (DATA_WIDTH),
    .SLOT_W     (SLOT_W)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (shadow_wr),
    .wr_slot  (cpu_slot),
    .wr_data  (cpu_value_i),
    .clr_en   (commit_emit),
    .clr_slot (slot),
    .rd_slot  (slot),
    .rd_data  (rd_data),
    .rd_dirty (rd_dirty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state                  <= IDLE;
      slot                   <= '0;
      vblank_prev            <= 1'b0;
      frame_count_o          <= '0;
      register_write_o       <= 1'b0;
      register_index_o       <= '0;
      register_write_value_o <= '0;
    end else begin
      vblank_prev <= in_vblank_i;
      if (rise) begin
        frame_count_o <= frame_count_o + 16'd1;
      end

      register_write_o <= pass_wr | commit_emit;
      if (pass_wr) begin
        register_index_o       <= cpu_index_i;
        register_write_value_o <= cpu_value_i;
      end else if (commit_emit) begin
        register_index_o       <= INDEX_WIDTH'(BASE_INDEX) + INDEX_WIDTH'(slot);
        register_write_value_o <= rd_data;
      end

      case (state)
        IDLE: begin
          if (rise) begin
            state <= COMMIT;
            slot  <= '0;
          end
        end
        COMMIT: begin
          if (commit_go) begin
            if (slot == SLOT_W'(NUM_SHADOW - 1)) begin
              state <= IDLE;
              slot  <= '0;
            end else begin
              slot <= slot + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          slot  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_register_shadow.sv
module tb_display_register_shadow;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_write_i;
  logic [6:0]  cpu_index_i;
  logic [15:0] cpu_value_i;
  logic        in_vblank_i;
  logic        register_write_o;
  logic [6:0]  register_index_o;
  logic [15:0] register_write_value_o;
  logic        commit_busy_o;
  logic [15:0] frame_count_o;

  display_register_shadow #(
    .BASE_INDEX  (2),
    .NUM_SHADOW  (8),
    .INDEX_WIDTH (7),
    .DATA_WIDTH  (16)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .cpu_write_i            (cpu_write_i),
    .cpu_index_i            (cpu_index_i),
    .cpu_value_i            (cpu_value_i),
    .in_vblank_i            (in_vblank_i),
    .register_write_o       (register_write_o),
    .register_index_o       (register_index_o),
    .register_write_value_o (register_write_value_o),
    .commit_busy_o          (commit_busy_o),
    .frame_count_o          (frame_count_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Shadow contents and pending flags per slot; a vblank rise opens a commit
  // window that visits slots 0..7 in order, one per cycle unless a
  // pass-through write takes the output that cycle.
  int unsigned m_sh [8];
  bit          m_dirty [8];
  bit          m_commit;
  int          m_pos;
  bit          m_vbprev;
  int unsigned m_frame;
  bit          m_w;
  int unsigned m_idx;
  int unsigned m_val;

  always @(posedge clk) begin : model
    bit rise;
    bit was;
    bit in_rng;
    int k;
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        m_sh[i] = 0;
        m_dirty[i] = 0;
      end
      m_commit = 0; m_pos = 0; m_vbprev = 0; m_frame = 0;
      m_w = 0; m_idx = 0; m_val = 0;
    end else begin
      rise     = in_vblank_i && !m_vbprev;
      m_vbprev = in_vblank_i;
      if (rise) m_frame = (m_frame + 1) % 65536;
      in_rng = (cpu_index_i >= 2) && (cpu_index_i < 10);
      was    = m_commit;
      m_w    = 0;
      if (cpu_write_i && !in_rng) begin
        m_w = 1; m_idx = cpu_index_i; m_val = cpu_value_i;
      end else if (was) begin
        if (m_dirty[m_pos]) begin
          m_w = 1; m_idx = 2 + m_pos; m_val = m_sh[m_pos];
          m_dirty[m_pos] = 0;
        end
        m_pos++;
        if (m_pos == 8) begin
          m_commit = 0;
          m_pos = 0;
        end
      end
      if (cpu_write_i && in_rng) begin
        k = int'(cpu_index_i) - 2;
        m_sh[k] = cpu_value_i;
        m_dirty[k] = 1;
      end
      if (!was && rise) begin
        m_commit = 1;
        m_pos = 0;
      end
    end
  end

  // ---------------- compare + strobe log ----------------
  bit          chk_en = 0;
  int          ncnt = 0;
  int          busy_cnt = 0;
  int unsigned slog [$];
  int          scyc [$];

  always @(negedge clk) begin
    ncnt++;
    if (chk_en) begin
      check("write_strobe", {31'd0, register_write_o}, {31'd0, m_w});
      if (m_w) begin
        check("write_index", {25'd0, register_index_o}, m_idx);
        check("write_value", {16'd0, register_write_value_o}, m_val);
      end
      check("busy", {31'd0, commit_busy_o}, {31'd0, m_commit});
      check("frame_count", {16'd0, frame_count_o}, m_frame);
      if (register_write_o === 1'b1) begin
        slog.push_back({9'd0, register_index_o, register_write_value_o});
        scyc.push_back(ncnt);
      end
      if (commit_busy_o === 1'b1) busy_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic w, input logic [6:0] idx, input logic [15:0] val);
    cpu_write_i = w;
    cpu_index_i = idx;
    cpu_value_i = val;
    @(posedge clk);
    #3;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 7'd0, 16'd0);
  endtask

  task automatic clear_log();
    slog.delete();
    scyc.delete();
    busy_cnt = 0;
  endtask

  task automatic vblank_pulse();
    in_vblank_i = 1'b1;
    idle(12);
    in_vblank_i = 1'b0;
    idle(2);
  endtask

  int s;

  initial begin
    reset = 1'b1; cpu_write_i = 0; cpu_index_i = 0; cpu_value_i = 0; in_vblank_i = 0;
    @(posedge clk); #3;
    chk_en = 1;

    // 1: reset holds everything at zero while vblank toggles
    for (int i = 0; i < 3; i++) begin
      in_vblank_i = 1'b1; idle(1);
      in_vblank_i = 1'b0; idle(1);
    end
    check("rst_frame", {16'd0, frame_count_o}, 32'd0);
    check("rst_no_strobes", slog.size(), 32'd0);
    check("rst_busy", {31'd0, commit_busy_o}, 32'd0);
    reset = 1'b0;
    idle(2);

    // 2: single shadowed write, committed at the next vblank
    clear_log();
    tick(1'b1, 7'd2, 16'h0050);
    idle(3);
    check("shadow_no_strobe", slog.size(), 32'd0);
    s = ncnt;
    vblank_pulse();
    check("t2_count", slog.size(), 32'd1);
    if (slog.size() >= 1) begin
      check("t2_entry", slog[0], {9'd0, 7'd2, 16'h0050});
      check("t2_latency", scyc[0], s + 3);
    end
    check("t2_busy_cycles", busy_cnt, 32'd8);
    check("t2_frame", {16'd0, frame_count_o}, 32'd1);

    // 3: last write wins, ascending order, nothing on a later vblank
    clear_log();
    tick(1'b1, 7'd2, 16'h0010);
    tick(1'b1, 7'd2, 16'h0020);
    tick(1'b1, 7'd9, 16'h0001);
    idle(2);
    vblank_pulse();
    check("t3_count", slog.size(), 32'd2);
    if (slog.size() >= 2) begin
      check("t3_first", slog[0], {9'd0, 7'd2, 16'h0020});
      check("t3_second", slog[1], {9'd0, 7'd9, 16'h0001});
    end
    vblank_pulse();
    check("t3_no_repeat", slog.size(), 32'd2);

    // 4: pass-through, idle and mid-commit (stalls the scan one cycle)
    clear_log();
    s = ncnt;
    tick(1'b1, 7'd0, 16'h1234);
    idle(2);
    check("t4_pass_count", slog.size(), 32'd1);
    if (slog.size() >= 1) begin
      check("t4_pass_entry", slog[0], {9'd0, 7'd0, 16'h1234});
      check("t4_pass_latency", scyc[0], s + 2);
    end
    clear_log();
    tick(1'b1, 7'd3, 16'h0077);
    in_vblank_i = 1'b1;
    idle(2);
    tick(1'b1, 7'd0, 16'h5678);
    idle(12);
    in_vblank_i = 1'b0;
    idle(2);
    check("t4_busy_stall", busy_cnt, 32'd9);
    check("t4_mid_count", slog.size(), 32'd2);
    if (slog.size() >= 2) begin
      check("t4_mid_pass", slog[0], {9'd0, 7'd0, 16'h5678});
      check("t4_mid_commit", slog[1], {9'd0, 7'd3, 16'h0077});
    end

    // 5: collision on slot 3 (index 5)
    clear_log();
    tick(1'b1, 7'd5, 16'h00AA);
    in_vblank_i = 1'b1;
    idle(4);
    tick(1'b1, 7'd5, 16'h00BB);
    idle(10);
    in_vblank_i = 1'b0;
    idle(2);
    check("t5_count", slog.size(), 32'd1);
    if (slog.size() >= 1) check("t5_old_value", slog[0], {9'd0, 7'd5, 16'h00AA});
    vblank_pulse();
    check("t5_next_count", slog.size(), 32'd2);
    if (slog.size() >= 2) check("t5_new_value", slog[1], {9'd0, 7'd5, 16'h00BB});

    // 6: reset in the third commit cycle aborts the scan and drops pending data
    for (int i = 0; i < 8; i++) tick(1'b1, 7'(2 + i), 16'(16'h0100 + i));
    in_vblank_i = 1'b1;
    idle(3);
    reset = 1'b1;
    idle(1);
    clear_log();
    check("t6_busy_after_rst", {31'd0, commit_busy_o}, 32'd0);
    check("t6_strobe_after_rst", {31'd0, register_write_o}, 32'd0);
    idle(2);
    reset = 1'b0;
    idle(12);
    in_vblank_i = 1'b0;
    idle(2);
    vblank_pulse();
    check("t6_no_strobes", slog.size(), 32'd0);

    // frame counter wrap: preload near the top, then three rises
    force dut.frame_count_o = 16'hFFFD;
    m_frame = 16'hFFFD;
    #1;
    release dut.frame_count_o;
    for (int i = 0; i < 3; i++) begin
      in_vblank_i = 1'b1; idle(1);
      in_vblank_i = 1'b0; idle(1);
    end
    check("frame_wrap", {16'd0, frame_count_o}, 32'd0);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
